// File: rtl/mips_pkg.sv
// mips_pkg: shared FSM state type and default widths for the sequential shifter
package mips_pkg;

    localparam int BITS_NUM_DEF = 32;
    localparam int SHAMT_W_DEF  = 5;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/shift_right_seq.sv
// shift_right_seq: one-bit-per-cycle right shifter (srl/sra) with start/busy/done handshake
// Arithmetic fill is built only when SHIFT_RIGHT_SEQ_ARITH_EN is defined; otherwise arith is ignored.
module shift_right_seq
    import mips_pkg::*;
#(
    parameter int bits_num = BITS_NUM_DEF,
    parameter int shamt_w  = SHAMT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [bits_num-1:0] in,
    input  logic [shamt_w-1:0]  shamt,
    input  logic                arith,
    output logic [bits_num-1:0] out,
    output logic                busy,
    output logic                done
);

    state_t              state, state_nxt;
    logic [bits_num-1:0] opr, opr_nxt;
    logic [shamt_w-1:0]  cnt, cnt_nxt;
    logic                fill;
    logic                load;

    assign load = (state == IDLE) && start;

`ifdef SHIFT_RIGHT_SEQ_ARITH_EN
    logic arith_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            arith_q <= 1'b0;
        else if (load)
            arith_q <= arith;
    end

    // sra keeps replicating the sign bit, which stays in the MSB throughout
    assign fill = arith_q & opr[bits_num-1];
`else
    logic unused_arith;

    assign unused_arith = arith;
    assign fill         = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        opr_nxt   = opr;
        cnt_nxt   = cnt;
        if (state == IDLE) begin
            if (start) begin
                opr_nxt   = in;
                cnt_nxt   = shamt;
                state_nxt = (shamt == '0) ? DONE : SHIFT;
            end
        end else if (state == SHIFT) begin
            opr_nxt   = {fill, opr[bits_num-1:1]};
            cnt_nxt   = cnt - 1'b1;
            state_nxt = (cnt == shamt_w'(1)) ? DONE : SHIFT;
        end else begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            opr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            opr   <= opr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign out  = opr;
    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_right_seq.sv
// tb_shift_right_seq: randomized self-checking bench for shift_right_seq against an arithmetic shift model
module tb_shift_right_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] in = '0;
    logic [4:0]  shamt = '0;
    logic        arith = 1'b0;
    logic [31:0] out;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    shift_right_seq dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in(in),
        .shamt(shamt),
        .arith(arith),
        .out(out),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] i, input logic [4:0] s, input logic a);
        logic signed [31:0] t;
        t = i;
`ifdef SHIFT_RIGHT_SEQ_ARITH_EN
        if (a) return 32'(t >>> s);
`endif
        return i >> s;
    endfunction

    // c counts falling edges after the load edge; done is seen at c = shamt+1
    task automatic do_op(input logic [31:0] i, input logic [4:0] s, input logic a,
                         output int lat, output int bcyc, output int dcnt,
                         output logic [31:0] o_done, output logic [31:0] o_hold);
        @(negedge clk);
        in = i; shamt = s; arith = a; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; in = $urandom; shamt = 5'($urandom); arith = 1'($urandom);
        lat = 0; bcyc = 0; dcnt = 0; o_done = '0; o_hold = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy) bcyc++;
            if (done) begin
                dcnt++;
                if (lat == 0) begin
                    lat = c;
                    o_done = out;
                end
            end
            if (lat != 0 && c == lat + 1) begin
                o_hold = out;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (out !== 32'h0) begin errors++; $display("FAIL reset_out got %h want 00000000", out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_op(input string name, input logic [31:0] i, input logic [4:0] s, input logic a,
                           input logic [31:0] want);
        int lat, bcyc, dcnt;
        logic [31:0] od, oh;
        do_op(i, s, a, lat, bcyc, dcnt, od, oh);
        checks++; if (lat !== int'(s) + 1) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, int'(s) + 1); end
        checks++; if (bcyc !== int'(s)) begin errors++; $display("FAIL %s_busy_cycles got %0d want %0d", name, bcyc, s); end
        checks++; if (dcnt !== 1) begin errors++; $display("FAIL %s_done_pulses got %0d want 1", name, dcnt); end
        checks++; if (od !== want) begin errors++; $display("FAIL %s_out got %h want %h", name, od, want); end
        checks++; if (oh !== want) begin errors++; $display("FAIL %s_out_hold got %h want %h", name, oh, want); end
    endtask

    task automatic test_directed();
        test_op("logical", 32'h80000000, 5'd4, 1'b0, 32'h08000000);
`ifdef SHIFT_RIGHT_SEQ_ARITH_EN
        test_op("arith", 32'h80000000, 5'd4, 1'b1, 32'hF8000000);
`else
        test_op("arith", 32'h80000000, 5'd4, 1'b1, 32'h08000000);
`endif
        test_op("zero", 32'h12345678, 5'd0, 1'b0, 32'h12345678);
        test_op("max", 32'hFFFFFFFF, 5'd31, 1'b0, 32'h00000001);
`ifdef SHIFT_RIGHT_SEQ_ARITH_EN
        test_op("max_arith", 32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF);
`else
        test_op("max_arith", 32'h80000000, 5'd31, 1'b1, 32'h00000001);
`endif
    endtask

    task automatic test_start_while_busy();
        logic [31:0] x, o;
        int dcnt, lat;
        x = $urandom | 32'h80000000;
        @(negedge clk);
        in = x; shamt = 5'd8; arith = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dcnt = 0; lat = 0; o = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = (c == 3);
            if (c == 3) begin
                in = 32'h0;
                shamt = 5'd1;
                arith = 1'b1;
            end
            if (done) begin
                dcnt++;
                lat = c;
                o = out;
            end
        end
        start = 1'b0;
        checks++; if (dcnt !== 1) begin errors++; $display("FAIL busy_start_pulses got %0d want 1", dcnt); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL busy_start_latency got %0d want 9", lat); end
        checks++; if (o !== (x >> 8)) begin errors++; $display("FAIL busy_start_out got %h want %h", o, x >> 8); end
    endtask

    task automatic test_reset_mid();
        int dcnt;
        @(negedge clk);
        in = 32'hDEADBEEF; shamt = 5'd10; arith = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (out !== 32'h0) begin errors++; $display("FAIL midrst_out got %h want 00000000", out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", done); end
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        checks++; if (dcnt !== 0) begin errors++; $display("FAIL midrst_activity got %0d want 0", dcnt); end
        test_op("after_rst", 32'hC0FFEE00, 5'd10, 1'b0, 32'hC0FFEE00 >> 10);
    endtask

    task automatic test_random();
        logic [31:0] i;
        logic [4:0]  s;
        logic        a;
        for (int n = 0; n < 20; n++) begin
            i = $urandom;
            s = 5'($urandom);
            a = 1'($urandom);
            test_op("random", i, s, a, model(i, s, a));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_while_busy();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
